sram_bank_issue_sched: RTL and testbench

In-order, dual-issue scheduler between the vector-cache request arbiter and the data SRAM banks. It buffers granted requests in a shared FIFO and issues up to two per cycle to the SRAM issue ports. A per-bank busy timer keeps a bank from being re-accessed before its read or write occupancy has elapsed. This replaces fixed-slot shift-register hazard masking with explicit per-bank occupancy counters.

---
 rtl/sram_bank_issue_sched.sv | 171 +++++++++++++++++
 tb/tb_sram_bank_issue_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_issue_sched.sv
// sram_bank_issue_sched: in-order dual-issue scheduler from the request
// arbiter into the data SRAM banks. Granted requests are buffered in a shared
// FIFO; up to two are issued per cycle. A per-bank occupancy timer blocks a
// bank until its previous read or write access has finished.
// Optional feature macro: SRAM_SCHED_PERF_CNT_EN enables the hazard stall
// counter on stall_cnt (tied to zero otherwise).
module sram_bank_issue_sched #(
    parameter int unsigned NUM_RAM  = 8,
    parameter int unsigned RAM_ID_W = $clog2(NUM_RAM),
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned RD_BUSY  = 2,
    parameter int unsigned WR_BUSY  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in0_vld,
    output logic                in0_rdy,
    input  logic [RAM_ID_W-1:0] in0_ram_id,
    input  logic                in0_wr,
    input  logic [TAG_W-1:0]    in0_tag,
    input  logic                in1_vld,
    output logic                in1_rdy,
    input  logic [RAM_ID_W-1:0] in1_ram_id,
    input  logic                in1_wr,
    input  logic [TAG_W-1:0]    in1_tag,
    output logic                out0_vld,
    output logic [RAM_ID_W-1:0] out0_ram_id,
    output logic                out0_wr,
    output logic [TAG_W-1:0]    out0_tag,
    output logic                out1_vld,
    output logic [RAM_ID_W-1:0] out1_ram_id,
    output logic                out1_wr,
    output logic [TAG_W-1:0]    out1_tag,
    input  logic                out_rdy,
    output logic [31:0]         stall_cnt
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned PTR_W    = IDX_W + 1;
    localparam int unsigned MAX_BUSY = (RD_BUSY > WR_BUSY) ? RD_BUSY : WR_BUSY;
    localparam int unsigned BUSY_W   = $clog2(MAX_BUSY) + 1;

    localparam logic [BUSY_W-1:0] RD_LOAD = BUSY_W'(RD_BUSY - 1);
    localparam logic [BUSY_W-1:0] WR_LOAD = BUSY_W'(WR_BUSY - 1);

    typedef struct packed {
        logic [RAM_ID_W-1:0] ram_id;
        logic                wr;
        logic [TAG_W-1:0]    tag;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [BUSY_W-1:0]  r_busy_cnt [NUM_RAM];

    logic [PTR_W-1:0]   w_count;
    logic               w_push0;
    logic               w_push1;
    logic [IDX_W-1:0]   w_wr_idx0;
    logic [IDX_W-1:0]   w_wr_idx1;
    logic [IDX_W-1:0]   w_rd_idx0;
    logic [IDX_W-1:0]   w_rd_idx1;
    entry_t             w_head;
    entry_t             w_head1;
    logic [NUM_RAM-1:0] w_bank_rdy;
    logic               w_out0_vld;
    logic               w_out1_vld;
    logic               w_iss0;
    logic               w_iss1;

    // Occupancy and ready flags depend only on the registered pointers
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign in0_rdy = (w_count <= PTR_W'(DEPTH - 1));
    assign in1_rdy = (w_count <= PTR_W'(DEPTH - 2));

    assign w_push0   = in0_vld && in0_rdy;
    assign w_push1   = in1_vld && in1_rdy;
    assign w_wr_idx0 = r_wr_ptr[IDX_W-1:0];
    assign w_wr_idx1 = w_push0 ? (w_wr_idx0 + IDX_W'(1)) : w_wr_idx0;

    assign w_rd_idx0 = r_rd_ptr[IDX_W-1:0];
    assign w_rd_idx1 = w_rd_idx0 + IDX_W'(1);
    assign w_head    = r_mem[w_rd_idx0];
    assign w_head1   = r_mem[w_rd_idx1];

    // A bank accepts a new access once its timer has drained to zero
    always_comb begin
        w_bank_rdy = '0;
        for (int b = 0; b < NUM_RAM; b++) begin
            w_bank_rdy[b] = (r_busy_cnt[b] == '0);
        end
    end

    // Issue selection: head first, head+1 only alongside head and on another bank
    assign w_out0_vld = (w_count != '0) && w_bank_rdy[w_head.ram_id];
    assign w_out1_vld = w_out0_vld
                     && (w_count >= PTR_W'(2))
                     && w_bank_rdy[w_head1.ram_id]
                     && (w_head1.ram_id != w_head.ram_id);

    assign w_iss0 = w_out0_vld && out_rdy;
    assign w_iss1 = w_out1_vld && out_rdy;

    assign out0_vld    = w_out0_vld;
    assign out0_ram_id = w_head.ram_id;
    assign out0_wr     = w_head.wr;
    assign out0_tag    = w_head.tag;
    assign out1_vld    = w_out1_vld;
    assign out1_ram_id = w_head1.ram_id;
    assign out1_wr     = w_head1.wr;
    assign out1_tag    = w_head1.tag;

    // FIFO storage and pointers; in0 lands before in1 on a dual push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push0) begin
                r_mem[w_wr_idx0] <= '{ram_id: in0_ram_id, wr: in0_wr, tag: in0_tag};
            end
            if (w_push1) begin
                r_mem[w_wr_idx1] <= '{ram_id: in1_ram_id, wr: in1_wr, tag: in1_tag};
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push0) + PTR_W'(w_push1);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_iss0) + PTR_W'(w_iss1);
        end
    end

    // Per-bank occupancy timers: load on issue, otherwise count down to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_RAM; b++) begin
                r_busy_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_RAM; b++) begin
                if (w_iss0 && (w_head.ram_id == RAM_ID_W'(b))) begin
                    r_busy_cnt[b] <= w_head.wr ? WR_LOAD : RD_LOAD;
                end else if (w_iss1 && (w_head1.ram_id == RAM_ID_W'(b))) begin
                    r_busy_cnt[b] <= w_head1.wr ? WR_LOAD : RD_LOAD;
                end else if (r_busy_cnt[b] != '0) begin
                    r_busy_cnt[b] <= r_busy_cnt[b] - BUSY_W'(1);
                end
            end
        end
    end

`ifdef SRAM_SCHED_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles where a queued head is held by a busy bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((w_count != '0) && !w_out0_vld && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_bank_issue_sched.sv
// Scoreboard bench for sram_bank_issue_sched: directed pushes queue their
// expected issues (cycle, port, bank, wr, tag); a negedge monitor pops and
// compares every issue the DUT makes.
module tb_sram_bank_issue_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_vld, in1_vld, in0_rdy, in1_rdy;
    logic [2:0] in0_ram_id, in1_ram_id;
    logic       in0_wr, in1_wr;
    logic [7:0] in0_tag, in1_tag;
    logic       out0_vld, out1_vld;
    logic [2:0] out0_ram_id, out1_ram_id;
    logic       out0_wr, out1_wr;
    logic [7:0] out0_tag, out1_tag;
    logic       out_rdy;
    logic [31:0] stall_cnt;

`ifdef SRAM_SCHED_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    sram_bank_issue_sched dut (
        .clk(clk), .rst(rst),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_ram_id(in0_ram_id), .in0_wr(in0_wr), .in0_tag(in0_tag),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_ram_id(in1_ram_id), .in1_wr(in1_wr), .in1_tag(in1_tag),
        .out0_vld(out0_vld), .out0_ram_id(out0_ram_id), .out0_wr(out0_wr), .out0_tag(out0_tag),
        .out1_vld(out1_vld), .out1_ram_id(out1_ram_id), .out1_wr(out1_wr), .out1_tag(out1_tag),
        .out_rdy(out_rdy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         port;
        logic [2:0] id;
        logic       wr;
        logic [7:0] tag;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_iss(input int c, input int p, input logic [2:0] id, input logic wr, input logic [7:0] tag);
        exp_t e;
        e.cyc = c; e.port = p; e.id = id; e.wr = wr; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_iss(input int p, input logic [2:0] id, input logic wr, input logic [7:0] tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_issue port=%0d bank=%0d wr=%0b tag=%0h at cycle %0d, required none", p, id, wr, tag, cyc);
        end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.port != p || e.id !== id || e.wr !== wr || e.tag !== tag) begin
                failures++;
                $display("FAIL issue actual cyc=%0d port=%0d bank=%0d wr=%0b tag=%0h required cyc=%0d port=%0d bank=%0d wr=%0b tag=%0h",
                         cyc, p, id, wr, tag, e.cyc, e.port, e.id, e.wr, e.tag);
            end
        end
    endtask

    // Monitor: every accepted issue must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_rdy) begin
            if (out0_vld) check_iss(0, out0_ram_id, out0_wr, out0_tag);
            if (out1_vld) check_iss(1, out1_ram_id, out1_wr, out1_tag);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] id0, input logic w0, input logic [7:0] t0,
                         input logic v1, input logic [2:0] id1, input logic w1, input logic [7:0] t1);
        in0_vld = v0; in0_ram_id = id0; in0_wr = w0; in0_tag = t0;
        in1_vld = v1; in1_ram_id = id1; in1_wr = w1; in1_tag = t1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1;
        out_rdy = 1'b1;
        idle();
        step(2);

        // Reset state
        chk("rst_out0_vld", 32'(out0_vld), 32'd0);
        chk("rst_out1_vld", 32'(out1_vld), 32'd0);
        chk("rst_in0_rdy", 32'(in0_rdy), 32'd1);
        chk("rst_in1_rdy", 32'(in1_rdy), 32'd1);
        chk("rst_out0_tag", 32'(out0_tag), 32'd0);
        chk("rst_out0_ram_id", 32'(out0_ram_id), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        step(2);

        // Single read to bank 3, then a second read that must wait out RD_BUSY
        c = cyc;
        drive(1'b1, 3'd3, 1'b0, 8'h11, 1'b0, 3'd0, 1'b0, 8'h00);
        expect_iss(c + 1, 0, 3'd3, 1'b0, 8'h11);
        step();
        drive(1'b1, 3'd3, 1'b0, 8'h12, 1'b0, 3'd0, 1'b0, 8'h00);
        expect_iss(c + 3, 0, 3'd3, 1'b0, 8'h12);
        step();
        idle();
        chk("t1_bank3_blocked", 32'(out0_vld), 32'd0);
        step(4);
        chk("t1_stall_cnt", stall_cnt, 32'(PERF * 1));

        // Dual issue to different banks; bank 5 reusable WR_BUSY later
        c = cyc;
        drive(1'b1, 3'd1, 1'b0, 8'h21, 1'b1, 3'd5, 1'b1, 8'h22);
        expect_iss(c + 1, 0, 3'd1, 1'b0, 8'h21);
        expect_iss(c + 1, 1, 3'd5, 1'b1, 8'h22);
        step();
        drive(1'b1, 3'd5, 1'b1, 8'h23, 1'b0, 3'd0, 1'b0, 8'h00);
        expect_iss(c + 5, 0, 3'd5, 1'b1, 8'h23);
        step();
        idle();
        step(2);
        chk("t2_bank5_busy", 32'(out0_vld), 32'd0);
        step(6);
        chk("t2_stall_cnt", stall_cnt, 32'(PERF * 4));

        // Same-bank pair: only the write issues, read follows WR_BUSY later
        c = cyc;
        drive(1'b1, 3'd2, 1'b1, 8'h31, 1'b1, 3'd2, 1'b0, 8'h32);
        expect_iss(c + 1, 0, 3'd2, 1'b1, 8'h31);
        expect_iss(c + 5, 0, 3'd2, 1'b0, 8'h32);
        step();
        idle();
        chk("t3_head_vld", 32'(out0_vld), 32'd1);
        chk("t3_no_pair", 32'(out1_vld), 32'd0);
        step(8);
        chk("t3_stall_cnt", stall_cnt, 32'(PERF * 7));

        // Backpressure: three entries held stable for five cycles
        out_rdy = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 8'h41, 1'b1, 3'd4, 1'b0, 8'h42);
        step();
        drive(1'b1, 3'd6, 1'b1, 8'h43, 1'b0, 3'd0, 1'b0, 8'h00);
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("t4_out0_vld", 32'(out0_vld), 32'd1);
            chk("t4_out1_vld", 32'(out1_vld), 32'd1);
            chk("t4_out0_tag", 32'(out0_tag), 32'h41);
            chk("t4_out1_tag", 32'(out1_tag), 32'h42);
            chk("t4_out1_ram_id", 32'(out1_ram_id), 32'd4);
            step();
        end
        c = cyc;
        out_rdy = 1'b1;
        expect_iss(c, 0, 3'd0, 1'b0, 8'h41);
        expect_iss(c, 1, 3'd4, 1'b0, 8'h42);
        expect_iss(c + 1, 0, 3'd6, 1'b1, 8'h43);
        step(6);
        chk("t4_stall_cnt", stall_cnt, 32'(PERF * 7));

        // Full FIFO: fill with out_rdy low, check readies at counts 6, 7 and 8
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'(2 * i), 1'b0, 8'(8'h50 + 2 * i), 1'b1, 3'(2 * i + 1), 1'b0, 8'(8'h51 + 2 * i));
            step();
        end
        idle();
        chk("t5_cnt6_in0_rdy", 32'(in0_rdy), 32'd1);
        chk("t5_cnt6_in1_rdy", 32'(in1_rdy), 32'd1);
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0, 8'h56);
        step();
        idle();
        chk("t5_cnt7_in0_rdy", 32'(in0_rdy), 32'd1);
        chk("t5_cnt7_in1_rdy", 32'(in1_rdy), 32'd0);
        drive(1'b1, 3'd7, 1'b0, 8'h57, 1'b0, 3'd0, 1'b0, 8'h00);
        step();
        idle();
        chk("t5_full_in0_rdy", 32'(in0_rdy), 32'd0);
        chk("t5_full_in1_rdy", 32'(in1_rdy), 32'd0);
        drive(1'b1, 3'd0, 1'b0, 8'h5E, 1'b1, 3'd1, 1'b0, 8'h5F);
        step();
        idle();
        c = cyc;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_iss(c + i, 0, 3'(2 * i), 1'b0, 8'(8'h50 + 2 * i));
            expect_iss(c + i, 1, 3'(2 * i + 1), 1'b0, 8'(8'h51 + 2 * i));
        end
        #1;
        chk("t5_no_pushthrough", 32'(in0_rdy), 32'd0);
        step(6);

        // Reset mid-operation with four queued entries and busy banks
        c = cyc;
        drive(1'b1, 3'd7, 1'b1, 8'h61, 1'b1, 3'd6, 1'b1, 8'h62);
        expect_iss(c + 1, 0, 3'd7, 1'b1, 8'h61);
        expect_iss(c + 1, 1, 3'd6, 1'b1, 8'h62);
        step();
        drive(1'b1, 3'd0, 1'b0, 8'h63, 1'b1, 3'd1, 1'b0, 8'h64);
        step();
        out_rdy = 1'b0;
        drive(1'b1, 3'd2, 1'b0, 8'h65, 1'b1, 3'd3, 1'b0, 8'h66);
        step();
        idle();
        chk("t6_pre_vld", 32'(out0_vld), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_out0_vld", 32'(out0_vld), 32'd0);
        chk("t6_rst_out1_vld", 32'(out1_vld), 32'd0);
        chk("t6_rst_in1_rdy", 32'(in1_rdy), 32'd1);
        chk("t6_rst_stall_cnt", stall_cnt, 32'd0);
        #1;
        rst = 1'b0;
        out_rdy = 1'b1;
        c = cyc;
        drive(1'b1, 3'd7, 1'b0, 8'h71, 1'b0, 3'd0, 1'b0, 8'h00);
        expect_iss(c + 1, 0, 3'd7, 1'b0, 8'h71);
        step();
        idle();
        step(4);

        // Drain: every expected issue must have been seen
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
